fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the IF stage: owns the PC register and drives a variable-latency instruction memory over a req/ack handshake.
//  Presents the fetched word and its PC (pcIF) to the IF/ID register, and loads the next-PC value from the NPC block each time the pipeline takes the instruction.
//  Flags misaligned fetch targets for the exception logic.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC loaded on reset; first fetch address
//  CNT_W      32             width of performance counters (FETCH_PERF_EN only)
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  npc_in       in   32     next PC from NPC block; sampled only on advance
//  stall_in     in   1      hazard unit: IF/ID must hold
//  imem_req     out  1      fetch request to instruction memory
//  imem_addr    out  32     fetch address (= pcIF while imem_req)
//  imem_ack     in   1      memory: imem_rdata valid this cycle
//  imem_rdata   in   32     fetched instruction word
//  pcIF         out  32     PC of current IF instruction
//  instrIF      out  32     fetched instruction (registered)
//  if_valid     out  1      instrIF/pcIF valid for IF/ID capture
//  fetch_err    out  1      misaligned fetch target, sticky until reset
//  perf_fetch   out  CNT_W  instructions delivered (FETCH_PERF_EN)
//  perf_wait    out  CNT_W  cycles spent waiting (FETCH_PERF_EN)
// BEHAVIOUR
//  Reset (async, immediate): state=BOOT, pcIF=RESET_PC, instrIF=0.
//   imem_req=0, if_valid=0, fetch_err=0, perf counters=0.
//  advance = if_valid & ~stall_in; the IF/ID register captures on the same edge.
//  States:
//   BOOT: outputs idle; next cycle -> REQ.
//   REQ:  imem_req=1, imem_addr=pcIF, held stable until ack.
//         imem_ack=1: instrIF<=imem_rdata, -> HOLD.
//   HOLD: if_valid=1, imem_req=0.
//         stall_in=1: stay; pcIF and instrIF frozen.
//         stall_in=0 (advance): if npc_in[1:0]==0 then pcIF<=npc_in, -> REQ.
//         Otherwise pcIF<=npc_in, instrIF<=0, fetch_err<=1, -> ERR.
//   ERR:  if_valid=1, instrIF=0 (nop), imem_req=0; advance keeps state. Exit only by reset.
//  Latency: ack at cycle t -> if_valid at t+1. Minimum 2 cycles per instruction (REQ, HOLD).
//  npc_in is sampled only on the advance edge; while waiting, ID holds, so npc_in is stable.
//  Branch/jump targets and delay-slot ordering are therefore handled solely by npc_in.
//  imem_ack outside REQ is ignored; imem_rdata is don't-care.
//  Reset asserted mid-request drops imem_req asynchronously. Any in-flight ack is discarded.
//  pcIF increments only through npc_in; no internal +4, no wrap handling beyond 32-bit overflow from npc_in.
// CONFIGURATION
//  FETCH_PERF_EN defined:
//   perf_fetch +1 per advance (wraps at 2^CNT_W).
//   perf_wait +1 per cycle in REQ without ack, or in HOLD with stall_in=1.
//  FETCH_PERF_EN undefined: counters not built; perf_fetch=perf_wait=0 constant; ports remain.
// TESTING
//  1. Reset release, ack 1 cycle after req, rdata=32'h2408_0001, stall=0, npc_in=pcIF+4
//     -> imem_addr=0x3000, then 0x3004; if_valid pulses once per 2 cycles.
//  2. Ack delayed 5 cycles at addr 0x3004
//     -> imem_req and imem_addr=0x3004 held all 5 cycles; if_valid=0 until the cycle after ack; perf_wait=4.
//  3. HOLD with stall_in=1 for 3 cycles, npc_in toggled
//     -> pcIF and instrIF unchanged; no new imem_req; the advance after stall loads the npc_in present at that edge.
//  4. Advance with npc_in=0x3042 (misaligned)
//     -> pcIF=0x3042, fetch_err=1, instrIF=0, if_valid=1, imem_req stays 0 thereafter.
//  5. Reset asserted during REQ, then imem_ack=1 with reset active
//     -> imem_req=0 same cycle; pcIF=0x3000; ack ignored; fetch restarts at 0x3000 via BOOT.
//  6. With FETCH_PERF_EN: 10 instructions at 1-cycle ack, no stalls
//     -> perf_fetch=10, perf_wait=0. Without FETCH_PERF_EN -> both read 0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: pipeline-side controls, instruction-memory handshake and status.
// master = fetch_ctrl, slave = pipeline/memory environment.
interface fetch_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      npc_in;
   logic             stall_in;
   logic             imem_req;
   logic [31:0]      imem_addr;
   logic             imem_ack;
   logic [31:0]      imem_rdata;
   logic [31:0]      pcIF;
   logic [31:0]      instrIF;
   logic             if_valid;
   logic             fetch_err;
   logic [CNT_W-1:0] perf_fetch;
   logic [CNT_W-1:0] perf_wait;

   modport master (
      input  npc_in, stall_in, imem_ack, imem_rdata,
      output imem_req, imem_addr, pcIF, instrIF, if_valid, fetch_err,
             perf_fetch, perf_wait
   );

   modport slave (
      output npc_in, stall_in, imem_ack, imem_rdata,
      input  imem_req, imem_addr, pcIF, instrIF, if_valid, fetch_err,
             perf_fetch, perf_wait
   );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, fetches over a req/ack handshake, hands words to IF/ID.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          CNT_W    = 32
) (
   input  logic         clk,
   input  logic         reset,
   fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {BOOT, REQ, HOLD, ERR} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        req_q;
   logic        vld_q;
   logic        err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         req_q   <= 1'b0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            BOOT: begin
               state_q <= REQ;
               req_q   <= 1'b1;
            end
            REQ: if (bus.imem_ack) begin
               instr_q <= bus.imem_rdata;
               req_q   <= 1'b0;
               vld_q   <= 1'b1;
               state_q <= HOLD;
            end
            HOLD: if (!bus.stall_in) begin
               pc_q <= bus.npc_in;
               if (bus.npc_in[1:0] == 2'b00) begin
                  vld_q   <= 1'b0;
                  req_q   <= 1'b1;
                  state_q <= REQ;
               end else begin
                  // Misaligned target: present a nop forever, only reset recovers.
                  instr_q <= '0;
                  err_q   <= 1'b1;
                  state_q <= ERR;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = pc_q;
   assign bus.pcIF      = pc_q;
   assign bus.instrIF   = instr_q;
   assign bus.if_valid  = vld_q;
   assign bus.fetch_err = err_q;

`ifdef FETCH_PERF_EN
   logic             advance;
   logic             wait_c;
   logic [CNT_W-1:0] pf_q, pf_d;
   logic [CNT_W-1:0] pw_q, pw_d;

   assign advance = vld_q & ~bus.stall_in;
   assign wait_c  = ((state_q == REQ) && !bus.imem_ack) ||
                    ((state_q == HOLD) && bus.stall_in);

   always_comb begin
      pf_d = pf_q;
      pw_d = pw_q;
      if (advance) pf_d = pf_q + CNT_W'(1);
      if (wait_c)  pw_d = pw_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pf_q <= '0;
         pw_q <= '0;
      end else begin
         pf_q <= pf_d;
         pw_q <= pw_d;
      end
   end

   assign bus.perf_fetch = pf_q;
   assign bus.perf_wait  = pw_q;
`else
   assign bus.perf_fetch = {CNT_W{1'b0}};
   assign bus.perf_wait  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a memory model pushes each delivered word,
// every pipeline advance pops and compares it against pcIF/instrIF.
module tb_fetch_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_ctrl_if #(.CNT_W(32)) bus ();

   fetch_ctrl #(
      .RESET_PC (32'h0000_3000),
      .CNT_W    (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          ack_dly  = 1;
   int          reqcnt   = 0;
   int          adv_cnt  = 0;
   logic        stall_nx = 1'b0;
   logic        auto_npc = 1'b1;
   logic [31:0] npc_nx   = 32'h0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", tag, act, exp);
      end
   endtask

   // One cycle: at the falling edge drive pipeline inputs and the memory model, score advances.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      bus.stall_in = stall_nx;
      bus.npc_in   = auto_npc ? bus.pcIF + 32'd4 : npc_nx;
      if (bus.imem_req) begin
         reqcnt++;
         if (reqcnt >= ack_dly) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = 32'h2408_0001 + (bus.imem_addr - 32'h3000);
            sb.push_back('{pc: bus.imem_addr, ins: bus.imem_rdata});
            reqcnt = 0;
         end else begin
            bus.imem_ack = 1'b0;
         end
      end else begin
         bus.imem_ack   = 1'b0;
         bus.imem_rdata = 32'hBAD0_BAD0;
         reqcnt = 0;
      end
      if (bus.if_valid && !bus.stall_in) begin
         adv_cnt++;
         if (!bus.fetch_err) begin
            if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
            else begin
               e = sb.pop_front();
               chk("sb_pc", bus.pcIF, e.pc);
               chk("sb_ins", bus.instrIF, e.ins);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int adv0;
      logic [31:0] pf_exp;
      reset          = 1'b1;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      bus.stall_in   = 1'b0;
      bus.npc_in     = 32'h0;
      #12;
      chk("rst_req",   32'(bus.imem_req),  32'd0);
      chk("rst_vld",   32'(bus.if_valid),  32'd0);
      chk("rst_pc",    bus.pcIF,           32'h3000);
      chk("rst_ins",   bus.instrIF,        32'h0);
      chk("rst_err",   32'(bus.fetch_err), 32'd0);
      chk("rst_pf",    bus.perf_fetch,     32'd0);
      chk("rst_pw",    bus.perf_wait,      32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("boot_req", 32'(bus.imem_req), 32'd0);

      // 1-cycle ack fetch at 0x3000
      tick();
      chk("t1_req",  32'(bus.imem_req), 32'd1);
      chk("t1_addr", bus.imem_addr,     32'h3000);
      chk("t1_vld",  32'(bus.if_valid), 32'd0);
      ack_dly = 5;
      tick();
      chk("t1_hvld", 32'(bus.if_valid), 32'd1);
      chk("t1_hreq", 32'(bus.imem_req), 32'd0);
      chk("t1_hins", bus.instrIF,       32'h2408_0001);

      // ack after 5 request cycles at 0x3004
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_req",  32'(bus.imem_req), 32'd1);
         chk("t2_addr", bus.imem_addr,     32'h3004);
         chk("t2_vld",  32'(bus.if_valid), 32'd0);
      end
      ack_dly  = 1;
      stall_nx = 1'b1;
      auto_npc = 1'b0;
      npc_nx   = 32'hDEAD_0000;
      tick();
      chk("t2_vld_after", 32'(bus.if_valid), 32'd1);
      chk("t2_pc", bus.pcIF, 32'h3004);
`ifdef FETCH_PERF_EN
      chk("t2_pw", bus.perf_wait, 32'd4);
`else
      chk("t2_pw", bus.perf_wait, 32'd0);
`endif

      // stall in HOLD for 3 cycles while npc_in toggles
      for (int i = 0; i < 2; i++) begin
         npc_nx = ~npc_nx & 32'hFFFF_FFFC;
         tick();
         chk("t3_pc",  bus.pcIF,           32'h3004);
         chk("t3_ins", bus.instrIF,        32'h2408_0005);
         chk("t3_req", 32'(bus.imem_req),  32'd0);
         chk("t3_vld", 32'(bus.if_valid),  32'd1);
      end
      stall_nx = 1'b0;
      npc_nx   = 32'h3100;
      tick();
      chk("t3_hold_pc", bus.pcIF, 32'h3004);
      tick();
      chk("t3_npc_addr", bus.imem_addr,    32'h3100);
      chk("t3_npc_req",  32'(bus.imem_req), 32'd1);

      // misaligned target
      npc_nx = 32'h3042;
      tick();
      chk("t4_pre_pc", bus.pcIF, 32'h3100);
      for (int i = 0; i < 4; i++) begin
         stall_nx = i[0];
         tick();
         chk("t4_pc",  bus.pcIF,            32'h3042);
         chk("t4_err", 32'(bus.fetch_err),  32'd1);
         chk("t4_ins", bus.instrIF,         32'h0);
         chk("t4_vld", 32'(bus.if_valid),   32'd1);
         chk("t4_req", 32'(bus.imem_req),   32'd0);
      end

      // reset in the middle of a request, with an ack arriving under reset
      stall_nx = 1'b0;
      auto_npc = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ack_dly = 3;
      tick();
      chk("t5_req_pre", 32'(bus.imem_req), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("t5_req_drop", 32'(bus.imem_req), 32'd0);
      chk("t5_pc",       bus.pcIF,          32'h3000);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hFFFF_FFFF;
      sb.delete();
      reqcnt = 0;
      @(posedge clk);
      #1;
      chk("t5_ack_ign_vld", 32'(bus.if_valid), 32'd0);
      chk("t5_ack_ign_ins", bus.instrIF,       32'h0);
      @(negedge clk);
      reset        = 1'b0;
      bus.imem_ack = 1'b0;
      ack_dly      = 1;
      #1 chk("t5_boot_req", 32'(bus.imem_req), 32'd0);

      // 10 instructions back-to-back
      adv0 = adv_cnt;
      tick();
      chk("t5_restart_addr", bus.imem_addr, 32'h3000);
      n = 1;
      while ((adv_cnt - adv0) < 10 && n < 100) begin
         tick();
         n++;
      end
      chk("t6_cycles", 32'(n), 32'd20);
      tick();
`ifdef FETCH_PERF_EN
      pf_exp = 32'd10;
`else
      pf_exp = 32'd0;
`endif
      chk("t6_pf", bus.perf_fetch, pf_exp);
      chk("t6_pw", bus.perf_wait,  32'd0);
      chk("t6_addr", bus.imem_addr, 32'h3028);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
